// File: rtl/mem_bank_pkg.sv
// Shared definitions for the memory bank request controller and its response FIFO.
package mem_bank_pkg;

  localparam int unsigned RSP_FIFO_DEPTH = 2;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_rsp_fifo2.sv
// Two-entry response FIFO with valid/ready on both sides; head data is always visible.
module mem_rsp_fifo2
  import mem_bank_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  localparam logic [1:0] CNT_FULL = 2'(RSP_FIFO_DEPTH);

  logic [W-1:0] data_q [RSP_FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push;
  logic         pop;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy next-state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bank_req_ctrl.sv
// Request controller for one RW port of a masked memory bank: clears the bank after
// reset, then forwards reads/writes and buffers read data in a 2-entry response FIFO.
module mem_bank_req_ctrl
  import mem_bank_pkg::*;
#(
  parameter int unsigned REG_DEPTH = 4,
  parameter int unsigned REG_WIDTH = 64,
  localparam int unsigned AW = $clog2(REG_DEPTH),
  localparam int unsigned SW = REG_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [REG_WIDTH-1:0] req_wdata,
  input  logic [SW-1:0]        req_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_rdata,
  output logic                 init_done,
  output logic                 mem_wmode,
  output logic [AW-1:0]        mem_addr,
  output logic [REG_WIDTH-1:0] mem_wmask,
  output logic [REG_WIDTH-1:0] mem_wdata,
  input  logic [REG_WIDTH-1:0] mem_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(REG_DEPTH - 1);

  state_e               state_q;
  state_e               state_d;
  logic [AW-1:0]        cnt_q;
  logic [AW-1:0]        cnt_d;
  logic [REG_WIDTH-1:0] strb_mask;
  logic [1:0]           rsp_count;
  logic                 fifo_in_ready;
  logic                 rd_push;

  for (genvar b = 0; b < SW; b++) begin : g_strb
    assign strb_mask[8*b +: 8] = {8{req_wstrb[b]}};
  end

  // FIFO full check is done on the count so req_ready never depends on rsp_ready.
  assign req_ready = (state_q == RUN) && (rsp_count < 2'd2);
  assign init_done = (state_q == RUN);
  assign rd_push   = req_valid && req_ready && !req_write;

  // Clear sequencing: walk every address once, then stay in RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Memory port drive: full-width zero writes while clearing, client traffic after.
  always_comb begin
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    case (state_q)
      INIT: begin
        mem_wmode = 1'b1;
        mem_addr  = cnt_q;
        mem_wmask = '1;
        mem_wdata = '0;
      end
      RUN: begin
        mem_wmode = req_valid && req_ready && req_write;
        mem_addr  = req_addr;
        mem_wmask = strb_mask;
        mem_wdata = req_wdata;
      end
      default: begin
        mem_wmode = 1'b0;
      end
    endcase
  end

  // State and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_rsp_fifo2 #(
    .W(REG_WIDTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_push),
    .in_ready (fifo_in_ready),
    .in_data  (mem_rdata),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data (rsp_rdata),
    .count    (rsp_count)
  );

  // fifo_in_ready mirrors the count check already folded into req_ready.
  logic unused_ok;
  assign unused_ok = fifo_in_ready;

endmodule

// File: tb/tb_mem_bank_req_ctrl.sv
// Directed bench for mem_bank_req_ctrl with a behavioural 4x64 masked memory model.
module tb_mem_bank_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        init_done;
  logic        mem_wmode;
  logic [1:0]  mem_addr;
  logic [63:0] mem_wmask;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem_q [0:3] = '{64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A,
                               64'hDEADBEEFDEADBEEF, 64'hFEEDFACEFEEDFACE};
  logic [63:0] exp_data [0:3];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wmode) mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end
  assign mem_rdata = mem_q[mem_addr];

  mem_bank_req_ctrl #(.REG_DEPTH(4), .REG_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    tick(); tick();
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_init_done", {63'd0, init_done}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);

    // Clear sequence after reset release
    rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("init_wmode", {63'd0, mem_wmode}, 64'd1);
      check("init_addr", {62'd0, mem_addr}, 64'(i));
      check("init_wdata", mem_wdata, 64'd0);
      check("init_wmask", mem_wmask, {64{1'b1}});
      check("init_req_ready", {63'd0, req_ready}, 64'd0);
      check("init_done_low", {63'd0, init_done}, 64'd0);
      tick();
    end
    check("init_done_high", {63'd0, init_done}, 64'd1);
    check("run_req_ready", {63'd0, req_ready}, 64'd1);

    // Full write then read of addr 2
    drive(1'b1, 1'b1, 2'd2, 64'h1122334455667788, 8'hFF);
    check("wr2_wmode", {63'd0, mem_wmode}, 64'd1);
    check("wr2_wmask", mem_wmask, {64{1'b1}});
    tick();
    drive(1'b1, 1'b0, 2'd2, 64'd0, 8'h00);
    check("rd2_wmode", {63'd0, mem_wmode}, 64'd0);
    check("rd2_rsp_valid_pre", {63'd0, rsp_valid}, 64'd0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    check("rd2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("rd2_rdata", rsp_rdata, 64'h1122334455667788);
    rsp_ready = 1'b1; #1;
    tick();
    check("rd2_popped", {63'd0, rsp_valid}, 64'd0);

    // Lower-half strobe write to addr 1
    drive(1'b1, 1'b1, 2'd1, {64{1'b1}}, 8'h0F);
    check("wr1_wmask", mem_wmask, 64'h00000000FFFFFFFF);
    tick();
    drive(1'b1, 1'b0, 2'd1, 64'd0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    check("rd1_rdata", rsp_rdata, 64'h00000000FFFFFFFF);
    tick();

    // Fill addr 0 and 3 with distinct values
    drive(1'b1, 1'b1, 2'd0, 64'hCAFE000000000001, 8'hFF); tick();
    drive(1'b1, 1'b1, 2'd3, 64'h0123456789ABCDEF, 8'hFF); tick();
    exp_data[0] = 64'hCAFE000000000001;
    exp_data[1] = 64'h00000000FFFFFFFF;
    exp_data[2] = 64'h1122334455667788;
    exp_data[3] = 64'h0123456789ABCDEF;

    // Backpressure: FIFO fills after two reads
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 64'd0, 8'h00);
    check("bp_ready0", {63'd0, req_ready}, 64'd1);
    tick();
    drive(1'b1, 1'b0, 2'd1, 64'd0, 8'h00);
    check("bp_ready1", {63'd0, req_ready}, 64'd1);
    tick();
    drive(1'b1, 1'b0, 2'd2, 64'd0, 8'h00);
    check("bp_full_ready", {63'd0, req_ready}, 64'd0);
    check("bp_head", rsp_rdata, exp_data[0]);
    tick();
    check("bp_hold_ready", {63'd0, req_ready}, 64'd0);
    check("bp_hold_head", rsp_rdata, exp_data[0]);
    rsp_ready = 1'b1; #1;
    check("bp_ready_indep", {63'd0, req_ready}, 64'd0);
    tick();
    check("bp_resp1_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_resp1_data", rsp_rdata, exp_data[1]);
    check("bp_third_ready", {63'd0, req_ready}, 64'd1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    check("bp_resp2_data", rsp_rdata, exp_data[2]);
    tick();
    check("bp_drained", {63'd0, rsp_valid}, 64'd0);

    // Zero-strobe write: accepted, no bits change
    drive(1'b1, 1'b1, 2'd2, {64{1'b1}}, 8'h00);
    check("zs_ready", {63'd0, req_ready}, 64'd1);
    check("zs_wmask", mem_wmask, 64'd0);
    tick();

    // Back-to-back reads with rsp_ready held high
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'(i), 64'd0, 8'h00);
      check("b2b_ready", {63'd0, req_ready}, 64'd1);
      if (i > 0) begin
        check("b2b_valid", {63'd0, rsp_valid}, 64'd1);
        check("b2b_data", rsp_rdata, exp_data[i-1]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    check("b2b_last_valid", {63'd0, rsp_valid}, 64'd1);
    check("b2b_last_data", rsp_rdata, exp_data[3]);
    tick();
    check("b2b_drained", {63'd0, rsp_valid}, 64'd0);

    // Reset with two responses queued
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 2'd3, 64'd0, 8'h00); tick();
    drive(1'b1, 1'b0, 2'd0, 64'd0, 8'h00); tick();
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    check("rr_full", {63'd0, req_ready}, 64'd0);
    rst = 1'b1; #1;
    tick();
    check("rr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rr_rsp_rdata", rsp_rdata, 64'd0);
    check("rr_init_done", {63'd0, init_done}, 64'd0);
    rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_init_addr", {62'd0, mem_addr}, 64'(i));
      check("rr_init_wmode", {63'd0, mem_wmode}, 64'd1);
      tick();
    end
    check("rr_init_done_high", {63'd0, init_done}, 64'd1);
    rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 64'd0, 8'h00); tick();
    drive(1'b0, 1'b0, 2'd0, 64'd0, 8'h00);
    check("rr_read_valid", {63'd0, rsp_valid}, 64'd1);
    check("rr_read_zero", rsp_rdata, 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bank_req_ctrl.md
MEM_BANK_REQ_CTRL -- requirements
Module: mem_bank_req_ctrl

Interface
REQ-001 The block SHALL take parameter REG_DEPTH, default 4, number of memory words; legal values are powers of two, >=2.
REQ-002 The block SHALL take parameter REG_WIDTH, default 64, word width in bits; legal values are multiples of 8.
REQ-003 The block SHALL have one clock and a synchronous active-high reset; AW = $clog2(REG_DEPTH), SW = REG_WIDTH/8.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  client request valid.
REQ-007 req_ready  out  1  controller accepts request this cycle.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  AW  word address.
REQ-010 req_wdata  in  REG_WIDTH  write data.
REQ-011 req_wstrb  in  SW  byte write strobes; bit b enables bits [8b+7:8b].
REQ-012 rsp_valid  out  1  read response valid.
REQ-013 rsp_ready  in  1  client accepts response.
REQ-014 rsp_rdata  out  REG_WIDTH  read response data.
REQ-015 init_done  out  1  memory clear complete.
REQ-016 mem_wmode, mem_addr (AW), mem_wmask (REG_WIDTH), mem_wdata (REG_WIDTH)  out  drive one RW port of the 2RW masked bank.
REQ-017 mem_rdata  in  REG_WIDTH  combinational read data from the same port.

Function
REQ-018 A request SHALL transfer only in a cycle where req_valid && req_ready are both 1; a response SHALL transfer only in a cycle where rsp_valid && rsp_ready are both 1.
REQ-019 The FSM SHALL have exactly two states: INIT and RUN; reset SHALL enter INIT with init counter = 0.
REQ-020 In INIT, the block SHALL drive mem_wmode=1, mem_addr=counter, mem_wmask=all-ones, mem_wdata=0, and increment the counter each cycle.
REQ-021 After the write to address REG_DEPTH-1, the FSM SHALL go to RUN; init_done SHALL be 1 from the next cycle onward (REG_DEPTH cycles after reset release).
REQ-022 req_ready SHALL equal (state==RUN) && (rsp_count < 2); it SHALL depend on neither req_valid nor req_write nor rsp_ready.
REQ-023 In RUN, mem_addr SHALL equal req_addr; mem_wmode SHALL be req_valid && req_ready && req_write.
REQ-024 mem_wmask SHALL be req_wstrb expanded per byte to REG_WIDTH bits, and mem_wdata SHALL equal req_wdata.
REQ-025 An accepted write SHALL produce no response and SHALL be visible to a read accepted in the following cycle.
REQ-026 An accepted read SHALL capture mem_rdata into a 2-entry response FIFO on that edge; rsp_valid SHALL rise the next cycle (latency 1).
REQ-027 Responses SHALL leave in request order; rsp_rdata SHALL show the FIFO head and SHALL hold stable while rsp_valid && !rsp_ready.
REQ-028 A simultaneous push and pop SHALL leave rsp_count unchanged; with rsp_ready held at 1, reads SHALL sustain one per cycle.
REQ-029 With rsp_count==2, req_ready SHALL be 0 for reads and writes alike.
REQ-030 A write with req_wstrb==0 SHALL be accepted and SHALL modify no bits.

Reset
REQ-031 Reset SHALL force req_ready=0, rsp_valid=0, rsp_count=0, init_done=0, FIFO pointers=0, rsp_rdata=0, state=INIT.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL discard queued responses and restart the clear from address 0.

Structure
REQ-033 A shared package mem_bank_pkg SHALL hold the state enum (INIT, RUN) and constant RSP_FIFO_DEPTH=2.
REQ-034 The response buffer SHALL be one sub-module, mem_rsp_fifo2, with a valid/ready interface on both sides.

Verification
REQ-035 Release reset, REG_DEPTH=4 -> mem_wmode=1 with addr 0,1,2,3 on four consecutive cycles, wdata=0; init_done=1 on the 5th cycle; req_ready=0 before that.
REQ-036 Write addr 2 data 0x1122334455667788 strb 0xFF, then read addr 2 next cycle -> one cycle later rsp_valid=1, rsp_rdata=0x1122334455667788.
REQ-037 Write addr 1 data all-ones strb 0x0F, then read addr 1 -> rsp_rdata=0x00000000FFFFFFFF; mem_wmask during write = 0x00000000FFFFFFFF.
REQ-038 rsp_ready=0, issue 3 reads (addrs 0,1,2) -> first two accepted, req_ready=0 on third; raise rsp_ready -> responses in order addr 0,1, then the third is accepted.
REQ-039 rsp_ready=1, back-to-back reads addrs 0..3 -> req_ready stays 1, four responses on consecutive cycles, rsp_count stays 1.
REQ-040 Assert rst with 2 responses queued -> rsp_valid=0 the next cycle, INIT restarts at addr 0, previously written data reads back 0 after init_done.
